// File: rtl/obi_mem_responder_pkg.sv
// Shared types and helpers for the OBI memory responder and its RAM.
package obi_mem_responder_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_rsp_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 8 * WORD_BYTES;
  localparam int unsigned CNT_W      = 4;

  // Request fields as presented by the initiator; sampled only at the grant edge
  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [WORD_BYTES-1:0] be;
    logic [DATA_W-1:0]     wdata;
  } mem_req_t;

  // Byte address falls inside the window [base, base + depth*4).
  // The offset subtraction wraps at 32 bits, so the lower bound is checked separately.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ({2'b00, off[31:2]} < depth);
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only updates on a read enable, so it also serves as the
// response holding register until the data is returned.
module sp_ram_be
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_addr,
  input  logic [WORD_BYTES-1:0] i_be,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane writes; contents are intentionally not reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < int'(WORD_BYTES); k++) begin
        if (i_be[k]) begin
          r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end
    end
  end

  // Synchronous read; value is held until the next read enable
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/obi_mem_responder.sv
// Responder side of the req/gnt/rvalid memory interface: word RAM with byte
// enables, programmable grant wait (GNT_WAIT 0..15) and response latency
// (RVALID_LAT 1..15), one outstanding transaction.
//
// Handshake: a request transfers on a rising edge where req_i && gnt_o; the
// initiator holds req_i and the request fields until that edge. Exactly one
// one-cycle rvalid_o pulse follows RVALID_LAT cycles after the grant edge;
// rvalid_o has no ready and cannot be stalled.
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH      = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned GNT_WAIT   = 0,
  parameter int unsigned RVALID_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [WORD_BYTES-1:0] be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output mem_rsp_state_e        dbg_state_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] GW = CNT_W'(GNT_WAIT);
  localparam logic [CNT_W-1:0] RL = CNT_W'(RVALID_LAT);
  localparam logic GW_ZERO        = (GNT_WAIT == 0);

  mem_req_t          w_req;
  mem_rsp_state_e    r_state;
  mem_rsp_state_e    w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic [CNT_W-1:0]  w_lat_cnt_nxt;
  logic              w_gnt_raw;
  logic              w_gnt;
  logic              w_in_range;
  logic [AW-1:0]     w_idx;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [DATA_W-1:0] w_ram_q;
  logic              w_rvalid_nxt;
  logic              w_rsp_rd_nxt;
  logic              w_rsp_err_nxt;
  logic              r_rvalid;
  logic              r_err;
  logic              r_rsp_rd;
  logic              r_rsp_err;

  assign w_req = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};

  // Address decode against the mapped window
  assign w_in_range = addr_in_range(w_req.addr, BASE_ADDR, 32'(DEPTH));
  assign w_idx      = AW'((w_req.addr - BASE_ADDR) >> 2);

  // Next-state, counters and grant; the rvalid cycle of RESP arbitrates like IDLE
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_lat_cnt_nxt  = r_lat_cnt;
    w_gnt_raw      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i && GW_ZERO) begin
          w_gnt_raw     = 1'b1;
          w_state_nxt   = RESP;
          w_lat_cnt_nxt = CNT_W'(1);
        end else if (req_i) begin
          w_state_nxt    = WAIT;
          w_wait_cnt_nxt = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!req_i) begin
          // Request withdrawn before grant: abandon it and start over
          w_state_nxt    = IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == GW) begin
          w_gnt_raw      = 1'b1;
          w_state_nxt    = RESP;
          w_wait_cnt_nxt = '0;
          w_lat_cnt_nxt  = CNT_W'(1);
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (r_lat_cnt == RL) begin
          if (req_i && GW_ZERO) begin
            w_gnt_raw     = 1'b1;
            w_state_nxt   = RESP;
            w_lat_cnt_nxt = CNT_W'(1);
          end else if (req_i) begin
            w_state_nxt    = WAIT;
            w_wait_cnt_nxt = CNT_W'(1);
            w_lat_cnt_nxt  = '0;
          end else begin
            w_state_nxt   = IDLE;
            w_lat_cnt_nxt = '0;
          end
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_wait_cnt_nxt = '0;
        w_lat_cnt_nxt  = '0;
      end
    endcase
  end

  // A handshake presented while reset is asserted is discarded, so grant is masked
  assign w_gnt = w_gnt_raw && !rst_i;
  assign gnt_o = w_gnt;

  // RAM access happens only at an in-range grant edge
  assign w_ram_we = w_gnt && w_req.we && w_in_range;
  assign w_ram_re = w_gnt && !w_req.we && w_in_range;

  // Response bookkeeping: rvalid lands when the latency counter reaches RVALID_LAT
  assign w_rvalid_nxt  = (w_state_nxt == RESP) && (w_lat_cnt_nxt == RL);
  assign w_rsp_rd_nxt  = w_gnt ? (!w_req.we && w_in_range) : r_rsp_rd;
  assign w_rsp_err_nxt = w_gnt ? !w_in_range : r_rsp_err;

  // FSM state and counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_lat_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_lat_cnt  <= w_lat_cnt_nxt;
    end
  end

  // Response registers: kind of the pending response plus the rvalid/err outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rsp_rd  <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rvalid  <= w_rvalid_nxt;
      r_err     <= w_rvalid_nxt && w_rsp_err_nxt;
      r_rsp_rd  <= w_rsp_rd_nxt;
      r_rsp_err <= w_rsp_err_nxt;
    end
  end

  sp_ram_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_idx),
    .i_be    (w_req.be),
    .i_wdata (w_req.wdata),
    .o_rdata (w_ram_q)
  );

  // The RAM read register holds the word until rvalid; zero outside read responses
  assign rdata_o     = (r_rvalid && r_rsp_rd) ? w_ram_q : '0;
  assign rvalid_o    = r_rvalid;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: four instances with different timing/mapping,
// directed scenarios followed by randomized traffic against a word-level model.
`timescale 1ns/1ps
module tb_obi_mem_responder;
  import obi_mem_responder_pkg::*;

  localparam int ND = 4;
  localparam int unsigned C_GW [ND] = '{0, 3, 0, 0};
  localparam int unsigned C_RL [ND] = '{1, 2, 1, 4};
  localparam logic [31:0] C_BA [ND] = '{32'h0, 32'h0, 32'h1000, 32'h0};
  localparam int unsigned C_DP [ND] = '{4096, 4096, 16, 64};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst    [ND];
  logic           req    [ND];
  logic           gnt    [ND];
  logic [31:0]    addr   [ND];
  logic           we     [ND];
  logic [3:0]     be     [ND];
  logic [31:0]    wdata  [ND];
  logic           rvalid [ND];
  logic [31:0]    rdata  [ND];
  logic           err    [ND];
  mem_rsp_state_e dbg    [ND];

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: model memory keyed by dut*65536 + word index, expected read queue
  logic [31:0] m_mem [int];
  logic [31:0] exp_q [$];
  logic [31:0] e_rd;
  logic        e_err;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    obi_mem_responder #(
      .DEPTH      (C_DP[g]),
      .BASE_ADDR  (C_BA[g]),
      .GNT_WAIT   (C_GW[g]),
      .RVALID_LAT (C_RL[g])
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .req_i       (req[g]),
      .gnt_o       (gnt[g]),
      .addr_i      (addr[g]),
      .we_i        (we[g]),
      .be_i        (be[g]),
      .wdata_i     (wdata[g]),
      .rvalid_o    (rvalid[g]),
      .rdata_o     (rdata[g]),
      .err_o       (err[g]),
      .dbg_state_o (dbg[g])
    );
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp_v);
    end
  endtask

  // reference model: address window, byte-merge writes, zero data on writes/errors
  function automatic logic model_in_range(input int d, input logic [31:0] a);
    return (a >= C_BA[d]) && (((a - C_BA[d]) >> 2) < 32'(C_DP[d]));
  endfunction

  task automatic model_access(input int d, input logic w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    int key;
    logic [31:0] word;
    if (!model_in_range(d, a)) begin
      rd = 32'h0;
      er = 1'b1;
      return;
    end
    key = d * 65536 + int'((a - C_BA[d]) >> 2);
    er  = 1'b0;
    word = m_mem.exists(key) ? m_mem[key] : 32'hxxxx_xxxx;
    if (w) begin
      for (int k = 0; k < 4; k++) if (b[k]) word[8*k +: 8] = wd[8*k +: 8];
      m_mem[key] = word;
      rd = 32'h0;
    end else begin
      rd = word;
    end
  endtask

  // driver: one isolated transaction, checks grant wait, latency, data, single pulse
  task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd, input bit chk_wait);
    int waits;
    int lat;
    logic [31:0] xrd;
    logic xer;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    waits = 0;
    #1;
    while (!gnt[d] && waits < 40) begin
      @(negedge clk);
      waits++;
      if (chk_wait && waits < int'(C_GW[d])) begin
        addr[d] = $urandom; wdata[d] = $urandom; we[d] = ~w; be[d] = ~b;
      end else begin
        addr[d] = a; wdata[d] = wd; we[d] = w; be[d] = b;
      end
      #1;
    end
    chk("gnt_seen", d, 32'(gnt[d]), 32'd1);
    if (!gnt[d]) begin
      req[d] = 1'b0;
      return;
    end
    if (chk_wait) chk("gnt_wait", d, 32'(waits), 32'(C_GW[d]));
    model_access(d, w, a, b, wd, xrd, xer);
    @(negedge clk);
    req[d] = 1'b0; we[d] = 1'b0; addr[d] = $urandom; wdata[d] = $urandom;
    lat = 1;
    while (!rvalid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rvalid_seen", d, 32'(rvalid[d]), 32'd1);
    chk("rvalid_lat", d, 32'(lat), 32'(C_RL[d]));
    chk("rdata", d, rdata[d], xrd);
    chk("err", d, 32'(err[d]), 32'(xer));
    @(negedge clk);
    chk("rvalid_pulse", d, 32'(rvalid[d]), 32'd0);
    chk("rdata_idle", d, rdata[d], 32'd0);
  endtask

  // driver: grant a request, then pulse reset while its response is pending
  task automatic txn_with_reset(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    int waits;
    logic [31:0] xrd;
    logic xer;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = 4'hF; wdata[d] = wd;
    waits = 0;
    #1;
    while (!gnt[d] && waits < 40) begin
      @(negedge clk);
      waits++;
      #1;
    end
    chk("rst_gnt_seen", d, 32'(gnt[d]), 32'd1);
    if (gnt[d]) model_access(d, w, a, 4'hF, wd, xrd, xer);
    @(negedge clk);
    req[d] = 1'b0; rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_rvalid", d, 32'(rvalid[d]), 32'd0);
      chk("rst_rdata", d, rdata[d], 32'd0);
      chk("rst_err", d, 32'(err[d]), 32'd0);
      chk("rst_state", d, 32'(dbg[d]), 32'(IDLE));
      @(negedge clk);
    end
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("reset_gnt", d, 32'(gnt[d]), 32'd0);
      chk("reset_rvalid", d, 32'(rvalid[d]), 32'd0);
      chk("reset_rdata", d, rdata[d], 32'd0);
      chk("reset_err", d, 32'(err[d]), 32'd0);
      chk("reset_state", d, 32'(dbg[d]), 32'(IDLE));
    end
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;

    // basic write then read, zero wait, latency 1
    do_txn(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1);
    do_txn(0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1);

    // byte enables, and a be=0 write that must leave the word alone
    do_txn(0, 1'b1, 32'h200, 4'hF, 32'h11223344, 1'b1);
    do_txn(0, 1'b1, 32'h200, 4'b0101, 32'hAABBCCDD, 1'b1);
    do_txn(0, 1'b0, 32'h200, 4'h0, 32'h0, 1'b1);
    chk("be_merge_value", 0, e_rd, e_rd);
    do_txn(0, 1'b1, 32'h200, 4'h0, 32'h99999999, 1'b1);
    do_txn(0, 1'b0, 32'h203, 4'h0, 32'h0, 1'b1);

    // wait 3 / latency 2, including scrambled fields while waiting
    do_txn(1, 1'b1, 32'h40, 4'hF, 32'hA5A5_0F0F, 1'b1);
    do_txn(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1);
    // request withdrawn during WAIT: no grant, back to IDLE, next request normal
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40;
    #1 chk("drop_gnt0", 1, 32'(gnt[1]), 32'd0);
    @(negedge clk);
    #1 chk("drop_gnt1", 1, 32'(gnt[1]), 32'd0);
    @(negedge clk);
    req[1] = 1'b0;
    #1 chk("drop_gnt2", 1, 32'(gnt[1]), 32'd0);
    @(negedge clk);
    chk("drop_state", 1, 32'(dbg[1]), 32'(IDLE));
    chk("drop_rvalid", 1, 32'(rvalid[1]), 32'd0);
    do_txn(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1);

    // back-to-back reads with req held continuously
    for (int i = 0; i < 8; i++) do_txn(0, 1'b1, 32'h300 + 32'(4 * i), 4'hF, $urandom, 1'b1);
    exp_q.delete();
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h300;
    for (int i = 0; i < 8; i++) begin
      #1 chk("b2b_gnt", 0, 32'(gnt[0]), 32'd1);
      model_access(0, 1'b0, 32'h300 + 32'(4 * i), 4'h0, 32'h0, e_rd, e_err);
      exp_q.push_back(e_rd);
      @(negedge clk);
      chk("b2b_rvalid", 0, 32'(rvalid[0]), 32'd1);
      chk("b2b_rdata", 0, rdata[0], exp_q.pop_front());
      if (i < 7) addr[0] = 32'h300 + 32'(4 * (i + 1));
      else req[0] = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end", 0, 32'(rvalid[0]), 32'd0);

    // back-to-back write then read of the same word returns the new data
    do_txn(0, 1'b1, 32'h380, 4'hF, 32'h0, 1'b1);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h380; be[0] = 4'hF; wdata[0] = 32'h5A5A1234;
    #1 chk("wr_rd_gnt_w", 0, 32'(gnt[0]), 32'd1);
    model_access(0, 1'b1, 32'h380, 4'hF, 32'h5A5A1234, e_rd, e_err);
    @(negedge clk);
    chk("wr_rd_rvalid_w", 0, 32'(rvalid[0]), 32'd1);
    chk("wr_rd_rdata_w", 0, rdata[0], 32'h0);
    we[0] = 1'b0;
    #1 chk("wr_rd_gnt_r", 0, 32'(gnt[0]), 32'd1);
    model_access(0, 1'b0, 32'h380, 4'h0, 32'h0, e_rd, e_err);
    @(negedge clk);
    req[0] = 1'b0;
    chk("wr_rd_rvalid_r", 0, 32'(rvalid[0]), 32'd1);
    chk("wr_rd_rdata_r", 0, rdata[0], e_rd);
    @(negedge clk);
    chk("wr_rd_end", 0, 32'(rvalid[0]), 32'd0);

    // address window: out-of-range accesses error and never alias into RAM
    do_txn(2, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b1);
    do_txn(2, 1'b1, 32'h103C, 4'hF, 32'h0BADC0DE, 1'b1);
    do_txn(2, 1'b1, 32'h1040, 4'hF, 32'h11111111, 1'b1);
    do_txn(2, 1'b1, 32'h0FFC, 4'hF, 32'h22222222, 1'b1);
    do_txn(2, 1'b0, 32'h1040, 4'h0, 32'h0, 1'b1);
    do_txn(2, 1'b0, 32'h0FFC, 4'h0, 32'h0, 1'b1);
    do_txn(2, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b1);
    do_txn(2, 1'b0, 32'h103C, 4'h0, 32'h0, 1'b1);

    // reset during a pending response (latency 4)
    txn_with_reset(3, 1'b1, 32'h44, 32'h7E57_DA7A);
    do_txn(3, 1'b0, 32'h44, 4'h0, 32'h0, 1'b1);
    txn_with_reset(3, 1'b0, 32'h44, 32'h0);
    do_txn(3, 1'b0, 32'h44, 4'h0, 32'h0, 1'b1);

    // randomized traffic against the model on every instance
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 16; i++) begin
        do_txn(d, 1'b1, (d == 2) ? 32'h1000 + 32'(4 * i) : 32'h80 + 32'(4 * i), 4'hF, $urandom, 1'b1);
      end
      for (int i = 0; i < 25; i++) begin
        logic [31:0] ra;
        ra = (d == 2) ? 32'h0FF0 + 32'($urandom_range(0, 32'h5F)) : 32'h80 + 32'($urandom_range(0, 63));
        do_txn(d, 1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
